// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared md-op codes, FSM states and op-classification helpers
package muldiv_pkg;

    localparam logic [2:0] MD_NONE  = 3'd0;
    localparam logic [2:0] MD_MULT  = 3'd1;
    localparam logic [2:0] MD_MULTU = 3'd2;
    localparam logic [2:0] MD_DIV   = 3'd3;
    localparam logic [2:0] MD_DIVU  = 3'd4;
    localparam logic [2:0] MD_MFHI  = 3'd5;
    localparam logic [2:0] MD_MFLO  = 3'd6;
    // MTLO shares this code; srcBE[0]=1 selects LO
    localparam logic [2:0] MD_MTHI  = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } md_state_t;

    function automatic logic op_is_arith(input logic [2:0] op);
        return op == MD_MULT || op == MD_MULTU || op == MD_DIV || op == MD_DIVU;
    endfunction

    function automatic logic op_is_div(input logic [2:0] op);
        return op == MD_DIV || op == MD_DIVU;
    endfunction

    function automatic logic op_is_signed(input logic [2:0] op);
        return op == MD_MULT || op == MD_DIV;
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// muldiv_iter: shift-add multiply / restoring divide datapath with sign fixup
module muldiv_iter
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    localparam int AW = 2 * WIDTH + 1;

    logic [AW-1:0]      acc, acc_step, shl, mult_next, div_next;
    logic [WIDTH-1:0]   opnd, mag_a, mag_b, q_fix, r_fix;
    logic [WIDTH:0]     sum, diff;
    logic [2*WIDTH-1:0] prod_fix;
    logic               div_mode, neg_q, neg_r, sgn;

    assign sgn   = op_is_signed(op);
    assign mag_a = (sgn && a[WIDTH-1]) ? -a : a;
    assign mag_b = (sgn && b[WIDTH-1]) ? -b : b;

    // Multiply: add multiplicand into the upper half when the low bit is set, then shift right
    assign sum       = acc[AW-1:WIDTH] + {1'b0, opnd};
    assign mult_next = {1'b0, acc[0] ? sum : acc[AW-1:WIDTH], acc[WIDTH-1:1]};

    // Divide: shift left, trial-subtract the divisor, keep the difference if non-negative
    assign shl      = acc << 1;
    assign diff     = shl[AW-1:WIDTH] - {1'b0, opnd};
    assign div_next = diff[WIDTH] ? shl : {diff, shl[WIDTH-1:1], 1'b1};

    assign acc_step = div_mode ? div_next : mult_next;

    // Results are taken from the post-step value so the last iteration can commit directly
    assign prod_fix = neg_q ? -acc_step[2*WIDTH-1:0] : acc_step[2*WIDTH-1:0];
    assign q_fix    = neg_q ? -acc_step[WIDTH-1:0] : acc_step[WIDTH-1:0];
    assign r_fix    = neg_r ? -acc_step[2*WIDTH-1:WIDTH] : acc_step[2*WIDTH-1:WIDTH];
    assign res_hi   = div_mode ? r_fix : prod_fix[2*WIDTH-1:WIDTH];
    assign res_lo   = div_mode ? q_fix : prod_fix[WIDTH-1:0];

    // Latch magnitudes and result signs on load; divide-by-zero keeps the quotient all ones
    always_ff @(posedge clk) begin
        if (rst) begin
            acc      <= '0;
            opnd     <= '0;
            div_mode <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
        end else if (load) begin
            div_mode <= op_is_div(op);
            opnd     <= op_is_div(op) ? mag_b : mag_a;
            acc      <= {{(WIDTH+1){1'b0}}, op_is_div(op) ? mag_a : mag_b};
            neg_q    <= sgn && (a[WIDTH-1] ^ b[WIDTH-1]) && !(op_is_div(op) && b == '0);
            neg_r    <= sgn && op_is_div(op) && a[WIDTH-1];
        end else if (step) begin
            acc <= acc_step;
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative mul/div sequencer with HI/LO registers and pipeline stall
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             startE,
    input  logic [2:0]       mdOpE,
    input  logic [WIDTH-1:0] srcAE,
    input  logic [WIDTH-1:0] srcBE,
    input  logic             flushE,
    output logic             stallE,
    output logic [WIDTH-1:0] hiloRdataE,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);

    md_state_t        state, state_next;
    logic [CW-1:0]    counter;
    logic [WIDTH-1:0] hi, lo, res_hi, res_lo;
    logic             load, step, commit, mt_wr;

    muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .step   (step),
        .op     (mdOpE),
        .a      (srcAE),
        .b      (srcBE),
        .res_hi (res_hi),
        .res_lo (res_lo)
    );

    assign mt_wr      = state == S_IDLE && startE && !flushE && mdOpE == MD_MTHI;
    assign busy       = state != S_IDLE;
    assign hiloRdataE = mdOpE == MD_MFHI ? hi : mdOpE == MD_MFLO ? lo : '0;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // Next state, stall and datapath controls; DONE ignores startE since the same instruction is still in EX
    always_comb begin
        state_next = state;
        stallE     = 1'b0;
        load       = 1'b0;
        step       = 1'b0;
        commit     = 1'b0;
        case (state)
            S_IDLE: begin
                if (startE && !flushE && op_is_arith(mdOpE)) begin
                    stallE     = 1'b1;
                    load       = 1'b1;
                    state_next = S_BUSY;
                end
            end
            S_BUSY: begin
                if (flushE) begin
                    state_next = S_IDLE;
                end else begin
                    stallE = 1'b1;
                    step   = 1'b1;
                    if (counter == '0) begin
                        commit     = 1'b1;
                        state_next = S_DONE;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Iteration counter
    always_ff @(posedge clk) begin
        if (rst)       counter <= '0;
        else if (load) counter <= CW'(WIDTH - 1);
        else if (step) counter <= counter - 1'b1;
    end

    // HI/LO: final iteration result or MTHI/MTLO write
    always_ff @(posedge clk) begin
        if (rst) begin
            hi <= '0;
            lo <= '0;
        end else if (commit) begin
            hi <= res_hi;
            lo <= res_lo;
        end else if (mt_wr) begin
            if (srcBE[0]) lo <= srcAE;
            else          hi <= srcAE;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: randomized self-checking bench against an arithmetic reference model
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk = 1'b0, rst = 1'b1, startE = 1'b0, flushE = 1'b0;
    logic [2:0]  mdOpE = MD_NONE;
    logic [31:0] srcAE = '0, srcBE = '0, hiloRdataE;
    logic        stallE, busy;
    logic [31:0] hi_m = '0, lo_m = '0;
    int          checks = 0, errors = 0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .startE     (startE),
        .mdOpE      (mdOpE),
        .srcAE      (srcAE),
        .srcBE      (srcBE),
        .flushE     (flushE),
        .stallE     (stallE),
        .hiloRdataE (hiloRdataE),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (op == MD_MULT) begin
            p = 64'(sa * sb);
            return p;
        end
        if (op == MD_MULTU) return {32'h0, a} * {32'h0, b};
        if (b == 32'h0) return {a, 32'hFFFFFFFF};
        if (op == MD_DIV) begin
            q = sa / sb;
            r = sa % sb;
            return {r[31:0], q[31:0]};
        end
        return {a % b, a / b};
    endfunction

    task automatic read_hilo(input string tag);
        mdOpE = MD_MFHI;
        #1 chk({tag, "_hi"}, hiloRdataE, hi_m);
        mdOpE = MD_MFLO;
        #1 chk({tag, "_lo"}, hiloRdataE, lo_m);
        mdOpE = MD_NONE;
    endtask

    task automatic run_md(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int stalls;
        logic [63:0] r;
        @(negedge clk);
        startE = 1'b1; mdOpE = op; srcAE = a; srcBE = b;
        #1 stalls = 0;
        while (stallE && stalls < 100) begin
            stalls++;
            @(negedge clk);
            #1;
        end
        chk({tag, "_stall"}, stalls, 33);
        chk({tag, "_busy_done"}, busy, 1);
        startE = 1'b0;
        r = ref_md(op, a, b);
        hi_m = r[63:32];
        lo_m = r[31:0];
        read_hilo(tag);
    endtask

    task automatic mt_write(input logic lo_sel, input logic [31:0] v);
        @(negedge clk);
        startE = 1'b1; mdOpE = MD_MTHI; srcAE = v; srcBE = {31'h0, lo_sel};
        #1 chk("mt_stall", stallE, 0);
        @(negedge clk);
        startE = 1'b0;
        if (lo_sel) lo_m = v;
        else        hi_m = v;
        read_hilo("mt");
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] c [4] = '{32'h0, 32'hFFFFFFFF, 32'h80000000, 32'h1};
        return ($urandom_range(0, 3) == 0) ? c[$urandom_range(0, 3)] : $urandom;
    endfunction

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1 chk("rst_stall", stallE, 0);
        chk("rst_busy", busy, 0);
        read_hilo("rst");

        run_md("multu_ff", MD_MULTU, 32'hFFFFFFFF, 32'h2);
        run_md("mult_neg", MD_MULT, -32'sd3, 32'sd7);
        run_md("div_neg", MD_DIV, -32'sd7, 32'sd2);
        run_md("divu_zero", MD_DIVU, 32'd100, 32'd0);
        run_md("div_ovf", MD_DIV, 32'h80000000, 32'hFFFFFFFF);
        run_md("div_zero_neg", MD_DIV, -32'sd9, 32'd0);

        // Undefined/none op and MFHI with startE must not stall
        @(negedge clk);
        startE = 1'b1; mdOpE = MD_NONE;
        #1 chk("none_stall", stallE, 0);
        mdOpE = MD_MFHI;
        #1 chk("mfhi_stall", stallE, 0);
        @(negedge clk);
        #1 chk("none_busy", busy, 0);
        startE = 1'b0; mdOpE = MD_NONE;

        // Flush in busy cycle 10 keeps HI/LO
        @(negedge clk);
        startE = 1'b1; mdOpE = MD_MULT; srcAE = 32'h12345; srcBE = 32'h777;
        repeat (10) @(negedge clk);
        flushE = 1'b1;
        #1 chk("flush_stall", stallE, 0);
        @(negedge clk);
        startE = 1'b0; flushE = 1'b0; mdOpE = MD_NONE;
        #1 chk("flush_busy", busy, 0);
        read_hilo("flush");
        mt_write(1'b0, 32'h1234);
        mt_write(1'b1, 32'hCAFE0001);

        for (int i = 0; i < 40; i++) begin
            logic [2:0] op;
            op = 3'(MD_MULT + 3'($urandom_range(0, 3)));
            run_md($sformatf("rnd%0d", i), op, pick(), pick());
        end

        // Reset mid-operation clears everything
        @(negedge clk);
        startE = 1'b1; mdOpE = MD_DIVU; srcAE = 32'd1000; srcBE = 32'd7;
        repeat (5) @(negedge clk);
        rst = 1'b1; startE = 1'b0; mdOpE = MD_NONE;
        @(negedge clk);
        rst = 1'b0;
        hi_m = '0;
        lo_m = '0;
        #1 chk("rst_mid_busy", busy, 0);
        chk("rst_mid_stall", stallE, 0);
        read_hilo("rst_mid");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
